// File: rtl/alu_ctrl.sv
// Command-queue front end for an external combinational 8-bit ALU: FIFO, one-shot issue, held response.
// Optional macro ALU_CTRL_CHAIN_EN lets a command take operand A from the previous result.
module alu_ctrl #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_opcode,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  input  logic       cmd_chain,
  output logic [3:0] alu_opcode,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic [7:0] alu_out,
  input  logic [3:0] alu_flag,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic [3:0] rsp_flag,
  output logic [3:0] rsp_tag
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_pop;
  logic            w_capture;
  logic            w_release;

  logic [3:0]      r_mem_op  [0:DEPTH-1];
  logic [7:0]      r_mem_a   [0:DEPTH-1];
  logic [7:0]      r_mem_b   [0:DEPTH-1];
  logic [3:0]      r_mem_tag [0:DEPTH-1];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [3:0]      r_tag_cnt;
  logic [3:0]      r_exec_tag;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic [7:0]      w_head_a;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  // Ready looks only at the registered occupancy, so a same-cycle pop never frees a slot early.
  assign cmd_ready = !rst && !w_full;
  assign w_push    = cmd_valid && cmd_ready;

`ifdef ALU_CTRL_CHAIN_EN
  logic            r_mem_chain [0:DEPTH-1];
  logic [7:0]      r_last;

  always_ff @(posedge clk) begin
    if (w_push) r_mem_chain[r_wr_ptr] <= cmd_chain;
  end

  always_ff @(posedge clk) begin
    if (rst)            r_last <= 8'h00;
    else if (w_capture) r_last <= alu_out;
  end

  assign w_head_a = r_mem_chain[r_rd_ptr] ? r_last : r_mem_a[r_rd_ptr];
`else
  logic            w_unused_chain;

  assign w_unused_chain = cmd_chain;
  assign w_head_a       = r_mem_a[r_rd_ptr];
`endif

  // Queue storage, written at the tail on each accepted command.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_op[r_wr_ptr]  <= cmd_opcode;
      r_mem_a[r_wr_ptr]   <= cmd_a;
      r_mem_b[r_wr_ptr]   <= cmd_b;
      r_mem_tag[r_wr_ptr] <= r_tag_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_tag_cnt <= 4'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr  <= r_wr_ptr + AW'(1);
        r_tag_cnt <= r_tag_cnt + 4'd1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (!w_empty) w_state_nxt = S_EXEC;
      S_EXEC:  w_state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_pop     = 1'b0;
    w_capture = 1'b0;
    w_release = 1'b0;
    case (r_state)
      S_IDLE:  w_pop     = !w_empty;
      S_EXEC:  w_capture = 1'b1;
      S_RESP:  w_release = rsp_ready;
      default: ;
    endcase
  end

  // Issue registers toward the ALU and the held response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_opcode <= 4'd0;
      alu_a      <= 8'h00;
      alu_b      <= 8'h00;
      r_exec_tag <= 4'd0;
      rsp_valid  <= 1'b0;
      rsp_data   <= 8'h00;
      rsp_flag   <= 4'd0;
      rsp_tag    <= 4'd0;
    end else begin
      if (w_pop) begin
        alu_opcode <= r_mem_op[r_rd_ptr];
        alu_a      <= w_head_a;
        alu_b      <= r_mem_b[r_rd_ptr];
        r_exec_tag <= r_mem_tag[r_rd_ptr];
      end
      if (w_capture) begin
        rsp_valid <= 1'b1;
        rsp_data  <= alu_out;
        rsp_flag  <= alu_flag;
        rsp_tag   <= r_exec_tag;
      end else if (w_release) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_ctrl.sv
// Bench for alu_ctrl paired with the team 8-bit ALU; directed scenarios plus randomized traffic
// checked against a queue-based response model.
module tb_alu_ctrl;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_ROR = 4'b1111;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_opcode;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic       cmd_chain;
  logic [3:0] alu_opcode;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_out;
  logic [3:0] alu_flag;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic [3:0] rsp_flag;
  logic [3:0] rsp_tag;

  int n_chk = 0;
  int n_bad = 0;

  alu_ctrl #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_chain(cmd_chain),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_flag(alu_flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_flag(rsp_flag), .rsp_tag(rsp_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Team ALU behaviour: returns {flags Z,N,C,V, result}.
  function automatic logic [11:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    logic [7:0] r;
    logic       c;
    logic       v;
    s = 9'd0;
    r = a;
    c = 1'b0;
    v = 1'b0;
    case (op)
      OP_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[7:0];
        c = s[8];
        v = (a[7] == b[7]) && (r[7] != a[7]);
      end
      OP_SUB: begin
        s = {1'b0, a} - {1'b0, b};
        r = s[7:0];
        c = s[8];
        v = (a[7] != b[7]) && (r[7] != a[7]);
      end
      OP_AND: r = a & b;
      OP_XOR: r = a ^ b;
      OP_ROR: begin
        r = {a[0], a[7:1]};
        c = a[0];
      end
      default: r = a;
    endcase
    return {(r == 8'h00), r[7], c, v, r};
  endfunction

  always_comb {alu_flag, alu_out} = alu_fn(alu_opcode, alu_a, alu_b);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Response model: commands are served strictly in acceptance order.
  typedef struct packed {
    logic [7:0] data;
    logic [3:0] flag;
    logic [3:0] tag;
  } rsp_t;

  rsp_t       exp_q[$];
  rsp_t       m_e;
  logic [3:0] m_tag = 4'd0;
  logic [7:0] m_last = 8'h00;
  logic [7:0] m_a;
  logic [11:0] m_r;
  int         n_rsp = 0;
  logic [3:0] last_tag = 4'd0;
  logic [7:0] last_data = 8'h00;
  logic       h_on = 1'b0;
  logic [7:0] h_data;
  logic [3:0] h_flag;
  logic [3:0] h_tag;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_tag  = 4'd0;
      m_last = 8'h00;
      h_on   = 1'b0;
    end else begin
      if (h_on) begin
        chk("hold_valid", 32'(rsp_valid), 32'h1);
        chk("hold_data", 32'(rsp_data), 32'(h_data));
        chk("hold_flag", 32'(rsp_flag), 32'(h_flag));
        chk("hold_tag", 32'(rsp_tag), 32'(h_tag));
      end
      h_on   = rsp_valid && !rsp_ready;
      h_data = rsp_data;
      h_flag = rsp_flag;
      h_tag  = rsp_tag;
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 32'(rsp_valid), 32'h0);
        end else begin
          m_e = exp_q.pop_front();
          chk("rsp_data", 32'(rsp_data), 32'(m_e.data));
          chk("rsp_flag", 32'(rsp_flag), 32'(m_e.flag));
          chk("rsp_tag", 32'(rsp_tag), 32'(m_e.tag));
          n_rsp++;
          last_tag  = rsp_tag;
          last_data = rsp_data;
        end
      end
      if (cmd_valid && cmd_ready) begin
        m_a = cmd_a;
`ifdef ALU_CTRL_CHAIN_EN
        if (cmd_chain) m_a = m_last;
`endif
        m_r = alu_fn(cmd_opcode, m_a, cmd_b);
        exp_q.push_back({m_r[7:0], m_r[11:8], m_tag});
        m_tag  = m_tag + 4'd1;
        m_last = m_r[7:0];
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic ch);
    logic acc;
    acc        = 1'b0;
    cmd_opcode = op;
    cmd_a      = a;
    cmd_b      = b;
    cmd_chain  = ch;
    cmd_valid  = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      acc = cmd_ready;
      step();
      if (acc) break;
    end
    cmd_valid = 1'b0;
    if (!acc) chk("send_timeout", 32'(acc), 32'h1);
  endtask

  // Returns at the negedge where rsp_valid is first seen high.
  task automatic wait_rsp();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("rsp_timeout", 32'(seen), 32'h1);
  endtask

  task automatic drain();
    rsp_ready = 1'b1;
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) step();
    chk("drain_left", 32'(exp_q.size()), 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ops [5];
    logic [3:0] f0;
    logic [3:0] t0;
    int         acc;
    int         n0;
    int         issued;

    ops = '{OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_ROR};
    rst = 1'b1; cmd_valid = 1'b0; cmd_opcode = 4'd0; cmd_a = 8'h00; cmd_b = 8'h00;
    cmd_chain = 1'b0; rsp_ready = 1'b1;

    // Reset values and ready around reset release.
    step();
    step();
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_data", 32'(rsp_data), 32'h0);
    chk("rst_rsp_tag", 32'(rsp_tag), 32'h0);
    chk("rst_alu_op", 32'(alu_opcode), 32'h0);
    chk("rst_alu_a", 32'(alu_a), 32'h0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(cmd_ready), 32'h1);
    step();

    // Latency of a single ADD, then ROR.
    send(OP_ADD, 8'h05, 8'h03, 1'b0);
    @(negedge clk);
    chk("lat_n0_valid", 32'(rsp_valid), 32'h0);
    step();
    @(negedge clk);
    chk("lat_exec_valid", 32'(rsp_valid), 32'h0);
    chk("lat_exec_op", 32'(alu_opcode), 32'(OP_ADD));
    chk("lat_exec_a", 32'(alu_a), 32'h05);
    chk("lat_exec_b", 32'(alu_b), 32'h03);
    step();
    @(negedge clk);
    chk("lat_n2_valid", 32'(rsp_valid), 32'h1);
    chk("add_data", 32'(rsp_data), 32'h08);
    chk("add_tag", 32'(rsp_tag), 32'h0);
    step();
    send(OP_ROR, 8'h01, 8'h00, 1'b0);
    wait_rsp();
    chk("ror_data", 32'(rsp_data), 32'h80);
    chk("ror_tag", 32'(rsp_tag), 32'h1);
    step();
    drain();

    // Capacity: one in flight plus four queued.
    do_reset();
    rsp_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      cmd_opcode = OP_ADD;
      cmd_a      = 8'(i);
      cmd_b      = 8'h10;
      cmd_chain  = 1'b0;
      cmd_valid  = 1'b1;
      @(negedge clk);
      if (cmd_ready) acc++;
      step();
    end
    cmd_valid = 1'b0;
    chk("cap_accepted", 32'(acc), 32'd5);
    @(negedge clk);
    chk("cap_ready_low", 32'(cmd_ready), 32'h0);
    step();
    n0 = n_rsp;
    drain();
    chk("cap_drained", 32'(n_rsp - n0), 32'd5);
    chk("cap_last_tag", 32'(last_tag), 32'd4);

    // Response held while the consumer stalls.
    rsp_ready = 1'b0;
    send(OP_XOR, 8'h55, 8'hAA, 1'b0);
    wait_rsp();
    f0 = rsp_flag;
    t0 = rsp_tag;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      chk("stall_valid", 32'(rsp_valid), 32'h1);
      chk("stall_data", 32'(rsp_data), 32'hFF);
      chk("stall_flag", 32'(rsp_flag), 32'(f0));
      chk("stall_tag", 32'(rsp_tag), 32'(t0));
      if (k < 2) step();
    end
    step();
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("release_pre", 32'(rsp_valid), 32'h1);
    step();
    @(negedge clk);
    chk("release_clear", 32'(rsp_valid), 32'h0);
    step();

    // Tag wrap after 16 commands.
    do_reset();
    n0 = n_rsp;
    for (int i = 0; i < 17; i++)
      send(ops[$urandom_range(0, 4)], 8'($urandom), 8'($urandom), 1'b0);
    drain();
    chk("wrap_count", 32'(n_rsp - n0), 32'd17);
    chk("wrap_tag", 32'(last_tag), 32'h0);

    // Chained operand A.
    do_reset();
    send(OP_ADD, 8'h05, 8'h03, 1'b0);
    send(OP_ADD, 8'h00, 8'h01, 1'b1);
    drain();
`ifdef ALU_CTRL_CHAIN_EN
    chk("chain_data", 32'(last_data), 32'h09);
`else
    chk("chain_data", 32'(last_data), 32'h01);
`endif

    // Reset while SUB is executing with two commands still queued.
    do_reset();
    rsp_ready = 1'b0;
    send(OP_AND, 8'h0F, 8'h3C, 1'b0);
    send(OP_SUB, 8'h80, 8'h80, 1'b0);
    send(OP_XOR, 8'h01, 8'h02, 1'b0);
    send(OP_ADD, 8'h03, 8'h04, 1'b0);
    wait_rsp();
    step();
    rsp_ready = 1'b1;
    step();
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("exec_sub_op", 32'(alu_opcode), 32'(OP_SUB));
    chk("exec_sub_valid", 32'(rsp_valid), 32'h0);
    chk("rst_high_ready", 32'(cmd_ready), 32'h0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst2_ready", 32'(cmd_ready), 32'h1);
    chk("rst2_rsp_data", 32'(rsp_data), 32'h0);
    chk("rst2_rsp_flag", 32'(rsp_flag), 32'h0);
    chk("rst2_alu_op", 32'(alu_opcode), 32'h0);
    chk("rst2_alu_a", 32'(alu_a), 32'h0);
    chk("rst2_alu_b", 32'(alu_b), 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      @(negedge clk);
      chk("rst2_no_rsp", 32'(rsp_valid), 32'h0);
    end
    step();
    send(OP_ADD, 8'h01, 8'h01, 1'b0);
    wait_rsp();
    chk("rst2_tag", 32'(rsp_tag), 32'h0);
    chk("rst2_data", 32'(rsp_data), 32'h02);
    step();
    drain();

    // Randomized traffic with random back-pressure.
    do_reset();
    issued = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      cmd_valid  = (issued < 60) && ($urandom_range(0, 1) == 1);
      cmd_opcode = ops[$urandom_range(0, 4)];
      cmd_a      = 8'($urandom);
      cmd_b      = 8'($urandom);
      cmd_chain  = 1'($urandom_range(0, 1));
      rsp_ready  = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (cmd_valid && cmd_ready) issued++;
      step();
    end
    cmd_valid = 1'b0;
    chk("rand_issued", 32'(issued), 32'd60);
    drain();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_ctrl.md
ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 Parameter DEPTH, default 4, command FIFO depth; power of two, minimum 2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 cmd_valid  input  1  command present.
REQ-005 cmd_ready  output  1  command FIFO can accept.
REQ-006 cmd_opcode  input  4  ALU opcode.
REQ-007 cmd_a  input  8  operand A.
REQ-008 cmd_b  input  8  operand B.
REQ-009 cmd_chain  input  1  request previous result as operand A.
REQ-010 alu_opcode  output  4  registered opcode driven to the external ALU.
REQ-011 alu_a  output  8  registered operand A to the ALU.
REQ-012 alu_b  output  8  registered operand B to the ALU.
REQ-013 alu_out  input  8  ALU result, combinational from alu_* outputs.
REQ-014 alu_flag  input  4  ALU flags; opaque, passed through unchanged.
REQ-015 rsp_valid  output  1  response present.
REQ-016 rsp_ready  input  1  consumer accepts response.
REQ-017 rsp_data  output  8  captured alu_out.
REQ-018 rsp_flag  output  4  captured alu_flag.
REQ-019 rsp_tag  output  4  sequence tag of the command that produced this response.

Function
REQ-020 Command handshake: push when cmd_valid && cmd_ready; cmd_ready = !fifo_full, derived from registered count only.
REQ-021 Each FIFO entry holds {opcode, a, b, chain, tag}; tag is a 4-bit accept counter, incremented per push, wrapping 15->0.
REQ-022 FSM states: IDLE, EXEC, RESP.
REQ-023 IDLE: if FIFO non-empty, pop the head, load alu_opcode/alu_a/alu_b, go to EXEC; else stay.
REQ-024 EXEC: exactly one cycle; at its closing edge capture alu_out->rsp_data, alu_flag->rsp_flag, entry tag->rsp_tag, set rsp_valid, go to RESP.
REQ-025 RESP: hold rsp_valid and all rsp_* stable until rsp_valid && rsp_ready; on that edge clear rsp_valid, go to IDLE.
REQ-026 Latency: command pushed into an empty FIFO at edge N enters EXEC at N+1 and rsp_valid is high after edge N+2; with rsp_ready high, steady throughput is one command per 3 cycles.
REQ-027 Same-cycle push and pop with FIFO neither full nor empty: count unchanged, both succeed.
REQ-028 FIFO full with a pop in the same cycle: cmd_ready stays low that cycle; no push.
REQ-029 Capacity: with rsp_ready held low, DEPTH+1 commands are accepted (one in flight, DEPTH queued) before cmd_ready drops.
REQ-030 Last-result register: updated with alu_out at each EXEC capture; used by chaining (see Configuration).
REQ-031 alu_* outputs hold their last-issued value outside EXEC.

Reset
REQ-032 rst at a rising edge: FIFO emptied, FSM to IDLE, tag counter 0, last-result 0, rsp_valid 0, rsp_data/rsp_flag/rsp_tag 0, alu_opcode/alu_a/alu_b 0.
REQ-033 rst dominates cmd_valid and rsp_ready in the same cycle; the in-flight command is dropped with no response.
REQ-034 cmd_ready is 0 while rst is high and 1 in the first cycle after rst deasserts.

Configuration
REQ-035 Macro ALU_CTRL_CHAIN_EN: when defined, an entry with chain=1 drives alu_a from the last-result register instead of its stored a.
REQ-036 Without ALU_CTRL_CHAIN_EN: cmd_chain is present but ignored; alu_a always equals the stored a; no last-result register is required.

Verification
REQ-037 Bench pairs alu_ctrl with the team 8-bit ALU (ADD=0000, SUB=0001, AND=0010, XOR=0011, ROR=1111) and covers the scenarios below.
REQ-038 After reset, ADD a=05 b=03 -> rsp_valid high after edge N+2, rsp_data=08, rsp_tag=0; ROR a=01 -> rsp_data=80, rsp_tag=1.
REQ-039 rsp_ready low, 6 back-to-back commands (DEPTH=4) -> exactly 5 accepted, cmd_ready low; releasing rsp_ready drains 5 responses in tag order 0..4.
REQ-040 rsp_ready held low 3 cycles on XOR 55^AA -> rsp_data=FF and rsp_flag/rsp_tag stable all 3 cycles; cleared one edge after rsp_ready rises.
REQ-041 17 commands -> 17th response carries rsp_tag=0 (wrap).
REQ-042 With ALU_CTRL_CHAIN_EN: ADD 05+03 then ADD chain=1 b=01 -> second rsp_data=09; without macro same stimulus with cmd_a=00 -> 01.
REQ-043 rst asserted during EXEC of SUB 80-80 with 2 commands queued -> no response, cmd_ready high after reset, next accepted command gets rsp_tag=0.
